// File: rtl/pc_pkg.sv
// Shared types and sizing helpers for the program counter and its return-address stack.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_CALL,
        SEL_RET
    } pc_sel_e;

    localparam int unsigned RAS_DEPTH_DEF = 4;
    localparam int unsigned RAS_PTR_W     = $clog2(RAS_DEPTH_DEF);

    function automatic int unsigned ras_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is a no-op reported through the underflow pulse.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int unsigned PTR_W     = RAS_PTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W:0]    count;

    assign top_ptr   = wptr - PTR_W'(1);
    assign dout      = mem[top_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_MAX);
    assign overflow  = push && full;
    assign underflow = pop && empty;

    // When full, wptr already points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            count <= '0;
        end else if (push) begin
            wptr <= wptr + PTR_W'(1);
            if (!full)
                count <= count + (PTR_W + 1)'(1);
        end else if (pop && !empty) begin
            wptr  <= top_ptr;
            count <= count - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with prioritised next-address select (ret > call > jmp > branch > seq),
// internal return-address stack and sticky overflow/underflow flags.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       STEP      = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_off,
    input  logic              jmp,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] tgt,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ovf,
    output logic              udf
);

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ras_top;
    logic              push;
    logic              pop;
    logic              ras_ovf;
    logic              ras_udf;

    assign pc_plus = pc + ADDR_W'(STEP);

    always_comb begin
        sel = SEL_SEQ;
        if (ret)
            sel = SEL_RET;
        else if (call)
            sel = SEL_CALL;
        else if (jmp)
            sel = SEL_JMP;
        else if (br_taken)
            sel = SEL_BR;
    end

    // Only the winning request touches the stack, and only while advancing.
    assign push = en && (sel == SEL_CALL);
    assign pop  = en && (sel == SEL_RET);

    always_comb begin
        pc_next = pc_plus;
        case (sel)
            SEL_RET:  pc_next = ras_empty ? RESET_VEC : ras_top;
            SEL_CALL: pc_next = tgt;
            SEL_JMP:  pc_next = tgt;
            SEL_BR:   pc_next = pc_plus + br_off;
            default:  pc_next = pc_plus;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc <= RESET_VEC;
        else if (en)
            pc <= pc_next;
    end

    // Set events win over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ras_ovf)
                ovf <= 1'b1;
            else if (clr_err)
                ovf <= 1'b0;
            if (ras_udf)
                udf <= 1'b1;
            else if (clr_err)
                udf <= 1'b0;
        end
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH),
        .PTR_W     (ras_ptr_w(RAS_DEPTH))
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (pc_plus),
        .dout      (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_ovf),
        .underflow (ras_udf)
    );

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter for the MIPS datapath, successor to the fixed 8-bit PC register. It holds the current instruction address and computes the next address from sequential step, relative branch, absolute jump, call and return requests. It contains an internal return-address stack (RAS) for call/return. It sits between the control unit (requests, stall) and instruction memory (address).

Parameters:
ADDR_W, 8, width of PC, offsets and targets
STEP, 1, sequential increment (1 = word-addressed instruction memory)
RESET_VEC, 0, PC value after reset and target of a failed return
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  asynchronous, active-low reset
en  in  1  advance enable; 0 = stall, all requests ignored
br_taken  in  1  take relative branch this cycle
br_off  in  ADDR_W  two's-complement branch offset
jmp  in  1  absolute jump
call  in  1  jump and push return address
ret  in  1  pop return address and jump to it
tgt  in  ADDR_W  absolute target for jmp/call
clr_err  in  1  clear sticky error flags
pc  out  ADDR_W  current instruction address (registered)
pc_plus  out  ADDR_W  pc+STEP, combinational from pc
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ovf  out  1  sticky: call executed while RAS full
udf  out  1  sticky: ret executed while RAS empty

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_VEC, RAS count=0, write pointer=0, ovf=0, udf=0; ras_empty=1, ras_full=0. Entry contents are don't-care. Release is taken on the next rising edge.
- All state updates occur on the rising clk edge only when en=1. With en=0, pc, RAS and flags hold. clr_err works regardless of en.
- Next-PC priority when en=1: ret > call > jmp > br_taken > sequential. Only the winning request has any effect; a losing call does not push.
- Sequential: pc <= pc+STEP.
- Branch: pc <= pc+STEP+br_off. All arithmetic is modulo 2^ADDR_W, and wrap-around is silent.
- Jump: pc <= tgt.
- Call: push pc+STEP, then pc <= tgt.
  - RAS not full: count+1.
  - RAS full: the oldest entry is overwritten (circular), count stays RAS_DEPTH, ovf <= 1.
- Ret:
  - RAS non-empty: pc <= top entry, count-1.
  - RAS empty: pc <= RESET_VEC, count stays 0, udf <= 1.
- Latency: one cycle from request to new pc. There are no bubbles. Back-to-back call/ret on consecutive cycles is legal; a ret immediately after a call returns that call's pc+STEP.
- Sticky flags: set as above. Cleared by clr_err on the next edge; a set event in the same cycle wins over clr_err. Cleared by reset.
- ras_empty and ras_full are decoded from the registered count (0..RAS_DEPTH, width clog2(RAS_DEPTH)+1).

Decomposition:
- Shared package pc_pkg holds:
  - the next-PC select enum (SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET);
  - the localparam for RAS pointer width.
- One sub-module, pc_ras: circular LIFO of RAS_DEPTH×ADDR_W.
  - Ports: push, pop, din, dout (top), empty, full, overflow pulse, underflow pulse.
  - Same clk/rst as pc_unit.
- pc_unit contains the priority select, adders, PC register and sticky flags.

Test Plan:
1. Reset and stall: with ADDR_W=8, RESET_VEC=0, hold rst=0 mid-run at pc=0x37; pc goes to 0x00 immediately, without waiting for a clock edge. After release, en=1 for 3 cycles gives pc=1,2,3. en=0 with jmp=1, tgt=0x80 leaves pc at 3.
2. Branch wrap: pc=0xFE, br_taken=1, br_off=0x03 gives pc=0x02. Then pc=0x10, br_off=0xF0 (−16) gives pc=0x01.
3. Call/return nesting: from pc=0x05, call to 0x40, then call to 0x60, then ret gives pc=0x41, then ret gives pc=0x06. ras_empty=1 at the end, ovf=udf=0.
4. RAS overflow (RAS_DEPTH=4): five calls from pcs 0x10, 0x20, 0x30, 0x40, 0x50 give ovf=1 and ras_full=1. Four rets return 0x51, 0x41, 0x31, 0x21. A fifth ret gives pc=0x00 and udf=1.
5. Priority: assert ret, call, jmp and br_taken together with RAS top=0x22; pc=0x22 and no push occurs (count decrements by 1). Then jmp with br_taken, tgt=0x90: pc=0x90.
6. Sticky clear: with ovf=1, pulse clr_err with en=0; ovf=0 next cycle. Asserting clr_err in the same cycle as an underflowing ret leaves udf=1.
